// File: rtl/sa_result_collector.sv
// sa_result_collector: de-skews the column-staggered acc_out bus of a SIZE-column
// weight-stationary systolic array into whole result rows and buffers them for a
// valid/ready consumer.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start, num_rows       job launch pulse and row count (sampled together in IDLE)
//   acc_in                array accumulator outputs, column j at [j*ACC_WIDTH +: ACC_WIDTH]
//   out_valid/out_ready   downstream row handshake; out_data uses acc_in packing
//   out_last              head row is the final row of the job
//   busy, done, overflow  job status; overflow is sticky until rst or an accepted start

// sa_fifo: generic circular buffer with occupancy count, no fall-through.
// Latency: pushed entry visible at the head the cycle after the push edge.
// Backpressure: push while full succeeds only with a same-edge pop; otherwise it is discarded.
module sa_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic [WIDTH-1:0]           head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign cnt      = cnt_q;
    // Masked so an empty FIFO never shows stale row data.
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign wr_en    = push_vld && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// sa_result_collector: column de-skew + row FIFO + job sequencing FSM.
// Latency: row r written at edge LAT+r+SIZE-1 after start, out_valid the cycle after.
// Backpressure: the array cannot stall; rows arriving while the FIFO is full are dropped and flagged.
module sa_result_collector #(
    parameter int SIZE       = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROW_W-1:0]          num_rows,
    input  logic [ACC_WIDTH*SIZE-1:0] acc_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH*SIZE-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);
    localparam int DW         = ACC_WIDTH * SIZE;
    // Edges spent in WAIT so that CAPTURE is active for the first aligned row.
    localparam int WAIT_EDGES = LAT + SIZE - 2;
    localparam int WCW        = (WAIT_EDGES < 2) ? 1 : $clog2(WAIT_EDGES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   nrows_q, nrows_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [DW-1:0]      aligned;
    logic               push_vld, push_last, pop;
    logic               fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic [DW:0]        head_dat;

    // Column j arrives j edges after column 0 of the same row, so it is held for
    // SIZE-1-j extra edges; the last column feeds straight through.
    for (genvar j = 0; j < SIZE; j++) begin : g_col
        localparam int D = SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = acc_in[j*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dly_q [D];
            logic [ACC_WIDTH-1:0] dly_d [D];
            always_comb begin
                dly_d[0] = acc_in[j*ACC_WIDTH +: ACC_WIDTH];
                for (int k = 1; k < D; k++) begin
                    dly_d[k] = dly_q[k-1];
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_q <= '{default: '0};
                end else begin
                    dly_q <= dly_d;
                end
            end
            assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = dly_q[D-1];
        end
    end

    sa_fifo #(.WIDTH(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat ({push_last, aligned}),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt),
        .head_dat (head_dat)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_dat[DW-1:0];
    assign out_last  = head_dat[DW];
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        row_d     = row_q;
        nrows_d   = nrows_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        push_vld  = 1'b0;
        push_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (num_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nrows_d = num_rows;
                        wcnt_d  = '0;
                        row_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCW'(1);
                if (wcnt_q == WCW'(WAIT_EDGES - 1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push_vld  = 1'b1;
                push_last = (row_q == nrows_q - ROW_W'(1));
                row_d     = row_q + ROW_W'(1);
                // Row is lost but still counted, so the job length is unchanged.
                if (fifo_full && !pop) begin
                    ovf_d = 1'b1;
                end
                if (push_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty || (pop && fifo_cnt == ($clog2(FIFO_DEPTH)+1)'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            row_q   <= '0;
            nrows_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            row_q   <= row_d;
            nrows_q <= nrows_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_sa_result_collector.sv
// tb_sa_result_collector: directed bench for sa_result_collector (SIZE=4, LAT=1,
// FIFO_DEPTH=4). Drives a skewed acc_in stream from the job's row values and checks
// rows, flags and status against hand-derived edge-by-edge expectations.
module tb_sa_result_collector;
    localparam int SIZE = 4;
    localparam int AW   = 32;
    localparam int LAT  = 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [7:0]           num_rows;
    logic [AW*SIZE-1:0]   acc_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [AW*SIZE-1:0]   out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    int n_chk;
    int n_bad;
    int ecnt;
    int job_rows;
    int base;

    sa_result_collector #(
        .SIZE(SIZE), .ACC_WIDTH(AW), .LAT(LAT), .FIFO_DEPTH(4), .ROW_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [AW*SIZE-1:0] got,
                         input logic [AW*SIZE-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW*SIZE-1:0] row_val(input int b, input int r);
        logic [AW*SIZE-1:0] v;
        v = '0;
        for (int j = 0; j < SIZE; j++) begin
            v[j*AW +: AW] = 32'(b + 16*r + j);
        end
        return v;
    endfunction

    // acc_in for the upcoming edge ecnt+1: row r col j is sampled at edge LAT+r+j.
    task automatic drive_acc();
        int r;
        for (int j = 0; j < SIZE; j++) begin
            r = ecnt + 1 - LAT - j;
            if (r >= 0 && r < job_rows) acc_in[j*AW +: AW] = 32'(base + 16*r + j);
            else                        acc_in[j*AW +: AW] = 32'hBAD0_0000 + 32'(j);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        drive_acc();
    endtask

    // Returns just after edge 0 with start already dropped.
    task automatic begin_job(input int n, input int b);
        start    = 1'b1;
        num_rows = 8'(n);
        job_rows = n;
        base     = b;
        ecnt     = -1;
        drive_acc();
        tick();
        start = 1'b0;
    endtask

    task automatic run_basic(input int b);
        out_ready = 1'b1;
        begin_job(2, b);
        check("t1_busy_e0", busy, 1);
        repeat (3) tick();
        check("t1_valid_e3", out_valid, 0);
        tick();
        check("t1_valid_e4", out_valid, 1);
        check("t1_row0", out_data, row_val(b, 0));
        check("t1_last_row0", out_last, 0);
        tick();
        check("t1_valid_e5", out_valid, 1);
        check("t1_row1", out_data, row_val(b, 1));
        check("t1_last_row1", out_last, 1);
        tick();
        check("t1_valid_e6", out_valid, 0);
        check("t1_done_e6", done, 1);
        check("t1_busy_e6", busy, 0);
        tick();
        check("t1_done_e7", done, 0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; num_rows = '0; out_ready = 1'b0;
        acc_in = '0; n_chk = 0; n_bad = 0; ecnt = 0; job_rows = 0; base = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // T1: two rows streamed straight out.
        run_basic(0);
        tick();

        // T2: six rows into a stalled 4-deep FIFO; rows 4,5 dropped.
        out_ready = 1'b0;
        begin_job(6, 256);
        repeat (7) tick();
        check("t2_ovf_e7", overflow, 0);
        check("t2_valid_e7", out_valid, 1);
        tick();
        check("t2_ovf_e8", overflow, 1);
        repeat (2) tick();
        check("t2_hold_row0", out_data, row_val(256, 0));
        check("t2_busy_e10", busy, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_row%0d", k), out_data, row_val(256, k));
            check($sformatf("t2_last%0d", k), out_last, 0);
            tick();
        end
        check("t2_done", done, 1);
        check("t2_valid_end", out_valid, 0);
        check("t2_ovf_sticky", overflow, 1);
        tick();

        // T6: zero-row job clears overflow and pulses done only.
        out_ready = 1'b0;
        begin_job(0, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 1);
        check("t6_ovf_clr", overflow, 0);
        check("t6_valid", out_valid, 0);
        tick();
        check("t6_done_end", done, 0);
        check("t6_busy_end", busy, 0);

        // T3: full FIFO with a same-edge pop accepts every row.
        out_ready = 1'b0;
        begin_job(6, 512);
        repeat (7) tick();
        check("t3_head_row0", out_data, row_val(512, 0));
        out_ready = 1'b1;
        tick();
        check("t3_ovf_e8", overflow, 0);
        for (int k = 1; k < 6; k++) begin
            check($sformatf("t3_row%0d", k), out_data, row_val(512, k));
            check($sformatf("t3_last%0d", k), out_last, (k == 5) ? 1 : 0);
            tick();
        end
        check("t3_done", done, 1);
        check("t3_ovf_end", overflow, 0);
        tick();

        // T4: a second start during CAPTURE is ignored.
        out_ready = 1'b1;
        begin_job(3, 768);
        repeat (4) tick();
        check("t4_row0", out_data, row_val(768, 0));
        start = 1'b1;
        num_rows = 8'd9;
        tick();
        start = 1'b0;
        check("t4_row1", out_data, row_val(768, 1));
        check("t4_last1", out_last, 0);
        tick();
        check("t4_row2", out_data, row_val(768, 2));
        check("t4_last2", out_last, 1);
        tick();
        check("t4_done", done, 1);
        check("t4_busy_e7", busy, 0);
        tick();
        check("t4_busy_e8", busy, 0);
        check("t4_valid_e8", out_valid, 0);
        check("t4_done_e8", done, 0);

        // T5: reset in the middle of CAPTURE, then a clean job.
        out_ready = 1'b0;
        begin_job(4, 1024);
        repeat (4) tick();
        check("t5_valid_pre", out_valid, 1);
        rst = 1'b1;
        tick();
        check("t5_valid", out_valid, 0);
        check("t5_data", out_data, 0);
        check("t5_last", out_last, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_ovf", overflow, 0);
        rst = 1'b0;
        tick();
        check("t5_no_done", done, 0);
        check("t5_idle", busy, 0);
        run_basic(1280);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
